route_sequencer: RTL
====================

Name: route_sequencer

Overview:
Interlocking sequencer between the operator route-request logic and the throat point drives.
- Accepts route requests (end track L1/L2/R3/R4 to station track S1–S4) and arbitrates them round-robin.
- Checks each request against the locked routes, drives the throat points, waits for them to settle, then locks the route.
- Releases routes on command.

Parameters:
SETTLE_CYCLES, 16, cycles point_en stays high before a route locks; minimum 1
HOLD_CYCLES, 1024, auto-release delay; used only with ROUTE_AUTO_RELEASE_EN
CNT_W, 16, width of the settle and hold counters

Ports:
CLOCK_50  input  1  system clock
RESET_N  input  1  synchronous active-low reset
req_valid  input  1  one-cycle route request strobe
req_end  input  2  end track: 0=L1, 1=L2, 2=R3, 3=R4
req_station  input  2  station track: 0=S1 … 3=S4
rel_valid  input  1  one-cycle release strobe
rel_end  input  2  end whose route is released
busy  output  1  FSM not in IDLE
point_en  output  4  per-end throat drive enable, high during MOVE only
point_cmd  output  8  per-end target station, bits [2e+1:2e]
route_lock  output  4  per-end route locked
route_station  output  8  per-end locked station, bits [2e+1:2e]
grant  output  1  one-cycle pulse: route locked
reject  output  1  one-cycle pulse: request refused
resp_end  output  2  end for the current grant/reject pulse

Behaviour:
Reset (RESET_N low at a CLOCK_50 edge):
- All outputs 0, all pending slots empty, FSM to IDLE, round-robin pointer to 0.

Request capture:
- One pending slot per end; req_valid writes {station} into slot req_end and sets its pending bit.
- A second request to an already-pending end overwrites it: latest wins.

Arbitration:
- In IDLE, select the first pending end at or after rr_ptr, ascending with wrap 3→0.
- Latch that end and its station, clear its pending bit, set rr_ptr = selected+1 mod 4, go to CHECK.
- If nothing is pending, stay in IDLE.

CHECK (1 cycle): the candidate (e, s) conflicts with a locked route (e', s') if any of:
- e' = e;
- s' = s;
- both ends on the same side (L1/L2 or R3/R4) and the upper-end route's station ≥ the lower-end route's station. Upper ends are L1 and R3, e.g. L1–S3 with L2–S2 conflicts.

CHECK outcome:
- Conflict: reject=1, resp_end=e, go to IDLE.
- No conflict: point_cmd[e]=s, point_en[e]=1, counter=SETTLE_CYCLES−1, go to MOVE.

MOVE:
- Decrement the counter; at 0, go to LOCK.
- Latency from IDLE selection to grant is SETTLE_CYCLES+2.

LOCK (1 cycle):
- point_en[e]=0, route_lock[e]=1, route_station[e]=s, grant=1, resp_end=e, go to IDLE.

Release (any state):
- rel_valid clears route_lock[rel_end], route_station[rel_end] and point_cmd[rel_end].
- If rel_end is the end in MOVE: clear point_en, go to IDLE, no grant/reject.
- If rel_end is the end in CHECK: the candidate is discarded and the FSM goes to IDLE.

Simultaneous events:
- Release and request to the same end in one cycle: the release applies and the request is captured as pending.
- Release and a conflict check in the same cycle: CHECK evaluates against the table after the release.

Pulses: grant and reject never assert together and are 0 in all other cycles.

Reset mid-MOVE: point_en drops on the next edge and no lock is created.

Optional Feature:
ROUTE_AUTO_RELEASE_EN
- Defined: each locked end has a HOLD_CYCLES down-counter loaded at LOCK. At expiry the route is released exactly as by rel_valid; an explicit release cancels the counter.
- Undefined: routes stay locked until rel_valid or reset, and no hold counters are built.

Test Plan:
- Reset, then req L2→S2 with SETTLE_CYCLES=16 → point_en=4'b0010 and point_cmd[3:2]=01 for 16 cycles; grant at selection+18; route_lock=4'b0010, route_station[3:2]=01.
- Lock L1→S3, then req L2→S2 → reject=1 with resp_end=1; table unchanged. Then req L2→S4 → grant.
- Lock R3→S1, then req L1→S1 (same station) → reject. Req R4→S4 → grant.
- Pulse req L1, L2, R3 and R4 (all non-conflicting) in one cycle each, consecutively → grants in order 0,1,2,3. With rr_ptr=2 and L1/R3 both pending, R3 is serviced first.
- Req L1→S1, then rel_valid rel_end=0 during MOVE → point_en=0, busy=0, no grant, route_lock=0. Same-cycle req and rel on end 3 → slot pending, later granted.
- ROUTE_AUTO_RELEASE_EN with HOLD_CYCLES=8: lock R4→S2 → route_lock[3] clears 8 cycles after grant. Without the macro it stays set for 100 cycles.

Source files
------------

// File: rtl/route_sequencer.sv
// Interlocking route sequencer: round-robin request arbitration, conflict check, point drive, lock.
// Optional build macro ROUTE_AUTO_RELEASE_EN adds per-end HOLD_CYCLES auto-release counters.
module route_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       req_valid,
  input  logic [1:0] req_end,
  input  logic [1:0] req_station,
  input  logic       rel_valid,
  input  logic [1:0] rel_end,
  output logic       busy,
  output logic [3:0] point_en,
  output logic [7:0] point_cmd,
  output logic [3:0] route_lock,
  output logic [7:0] route_station,
  output logic       grant,
  output logic       reject,
  output logic [1:0] resp_end
);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_MOVE, ST_LOCK} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         pend_reg, pend_next;
  logic [7:0]         slot_reg, slot_next;
  logic [1:0]         rr_ptr_reg, rr_ptr_next;
  logic [1:0]         cand_end_reg, cand_end_next;
  logic [1:0]         cand_sta_reg, cand_sta_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [3:0]         point_en_reg, point_en_next;
  logic [7:0]         point_cmd_reg, point_cmd_next;
  logic [3:0]         route_lock_reg, route_lock_next;
  logic [7:0]         route_station_reg, route_station_next;
  logic               grant_reg, grant_next;
  logic               reject_reg, reject_next;
  logic [1:0]         resp_end_reg, resp_end_next;

  logic [3:0]         rel_mask;
  logic [3:0]         expire_mask;
  logic [3:0]         lock_eff;
  logic [3:0]         lock_set;
  logic               sel_found;
  logic [1:0]         sel_end;
  logic [1:0]         arb_idx;
  logic               conflict;
  logic [1:0]         lk_sta;
  logic [1:0]         jj;

  // Explicit releases and hold expiries are handled identically
  always_comb begin
    rel_mask = expire_mask;
    if (rel_valid) rel_mask[rel_end] = 1'b1;
  end

  assign lock_eff = route_lock_reg & ~rel_mask;

  always_comb begin
    sel_found = 1'b0;
    sel_end   = 2'd0;
    arb_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      arb_idx = rr_ptr_reg + 2'(k);
      if (!sel_found && pend_reg[arb_idx]) begin
        sel_found = 1'b1;
        sel_end   = arb_idx;
      end
    end
  end

  // Same-side crossing: the upper end (even index) must use a lower-numbered station
  always_comb begin
    conflict = 1'b0;
    lk_sta   = 2'd0;
    jj       = 2'd0;
    for (int j = 0; j < 4; j++) begin
      jj     = 2'(j);
      lk_sta = route_station_reg[2*j +: 2];
      if (lock_eff[j]) begin
        if (jj == cand_end_reg || lk_sta == cand_sta_reg) begin
          conflict = 1'b1;
        end else if (jj[1] == cand_end_reg[1]) begin
          if (!cand_end_reg[0] && cand_sta_reg >= lk_sta) conflict = 1'b1;
          if (cand_end_reg[0] && lk_sta >= cand_sta_reg) conflict = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    pend_next          = pend_reg;
    slot_next          = slot_reg;
    rr_ptr_next        = rr_ptr_reg;
    cand_end_next      = cand_end_reg;
    cand_sta_next      = cand_sta_reg;
    cnt_next           = cnt_reg;
    point_en_next      = point_en_reg;
    point_cmd_next     = point_cmd_reg;
    route_lock_next    = route_lock_reg & ~rel_mask;
    route_station_next = route_station_reg;
    grant_next         = 1'b0;
    reject_next        = 1'b0;
    resp_end_next      = resp_end_reg;
    lock_set           = 4'd0;

    for (int j = 0; j < 4; j++) begin
      if (rel_mask[j]) begin
        route_station_next[2*j +: 2] = 2'd0;
        point_cmd_next[2*j +: 2]     = 2'd0;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (sel_found) begin
          cand_end_next      = sel_end;
          cand_sta_next      = slot_reg[{sel_end, 1'b0} +: 2];
          pend_next[sel_end] = 1'b0;
          rr_ptr_next        = sel_end + 2'd1;
          state_next         = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rel_mask[cand_end_reg]) begin
          state_next = ST_IDLE;
        end else if (conflict) begin
          reject_next   = 1'b1;
          resp_end_next = cand_end_reg;
          state_next    = ST_IDLE;
        end else begin
          point_cmd_next[{cand_end_reg, 1'b0} +: 2] = cand_sta_reg;
          point_en_next[cand_end_reg]               = 1'b1;
          cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
          state_next = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (rel_mask[cand_end_reg]) begin
          point_en_next = 4'd0;
          state_next    = ST_IDLE;
        end else if (cnt_reg == '0) begin
          point_en_next                                 = 4'd0;
          route_lock_next[cand_end_reg]                 = 1'b1;
          route_station_next[{cand_end_reg, 1'b0} +: 2] = cand_sta_reg;
          grant_next             = 1'b1;
          resp_end_next          = cand_end_reg;
          lock_set[cand_end_reg] = 1'b1;
          state_next             = ST_LOCK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_LOCK:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // A capture overrides the arbitration clear so a same-cycle request is never lost
    if (req_valid) begin
      pend_next[req_end]                = 1'b1;
      slot_next[{req_end, 1'b0} +: 2]   = req_station;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_reg         <= ST_IDLE;
      pend_reg          <= '0;
      slot_reg          <= '0;
      rr_ptr_reg        <= '0;
      cand_end_reg      <= '0;
      cand_sta_reg      <= '0;
      cnt_reg           <= '0;
      point_en_reg      <= '0;
      point_cmd_reg     <= '0;
      route_lock_reg    <= '0;
      route_station_reg <= '0;
      grant_reg         <= 1'b0;
      reject_reg        <= 1'b0;
      resp_end_reg      <= '0;
    end else begin
      state_reg         <= state_next;
      pend_reg          <= pend_next;
      slot_reg          <= slot_next;
      rr_ptr_reg        <= rr_ptr_next;
      cand_end_reg      <= cand_end_next;
      cand_sta_reg      <= cand_sta_next;
      cnt_reg           <= cnt_next;
      point_en_reg      <= point_en_next;
      point_cmd_reg     <= point_cmd_next;
      route_lock_reg    <= route_lock_next;
      route_station_reg <= route_station_next;
      grant_reg         <= grant_next;
      reject_reg        <= reject_next;
      resp_end_reg      <= resp_end_next;
    end
  end

`ifdef ROUTE_AUTO_RELEASE_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_hold
    logic [CNT_W-1:0] hold_cnt_reg;
    always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
        hold_cnt_reg <= '0;
      end else if (lock_set[gi]) begin
        hold_cnt_reg <= CNT_W'(HOLD_CYCLES - 1);
      end else if (rel_mask[gi]) begin
        hold_cnt_reg <= '0;
      end else if (route_lock_reg[gi] && hold_cnt_reg != '0) begin
        hold_cnt_reg <= hold_cnt_reg - CNT_W'(1);
      end
    end
    assign expire_mask[gi] = route_lock_reg[gi] && (hold_cnt_reg == '0);
  end
`else
  logic unused_hold;
  assign expire_mask = 4'd0;
  assign unused_hold = (HOLD_CYCLES != 0) ^ (|lock_set);
`endif

  assign busy          = (state_reg != ST_IDLE);
  assign point_en      = point_en_reg;
  assign point_cmd     = point_cmd_reg;
  assign route_lock    = route_lock_reg;
  assign route_station = route_station_reg;
  assign grant         = grant_reg;
  assign reject        = reject_reg;
  assign resp_end      = resp_end_reg;

endmodule
